// File: rtl/clock_pkg.sv
// Shared definitions for the multi-phase clock generator: parameter defaults
// and helpers for extracting and clamping per-channel phase values.
package clock_pkg;

    localparam int CW_DEFAULT           = 8;
    localparam int DEFAULT_HALF_DEFAULT = 4;

    // Helpers work on fixed wide fields; callers cast to their own widths.
    // Packed phase vectors therefore must fit in MAX_VEC bits.
    localparam int FIELD_W = 32;
    localparam int MAX_VEC = 256;

    function automatic logic [FIELD_W-1:0] clamp_phase(
        input logic [FIELD_W-1:0] ph,
        input logic [FIELD_W-1:0] h
    );
        return (ph > h - FIELD_W'(1)) ? h - FIELD_W'(1) : ph;
    endfunction

    function automatic logic [FIELD_W-1:0] phase_slice(
        input logic [MAX_VEC-1:0] vec,
        input int                 i,
        input int                 cw
    );
        logic [MAX_VEC-1:0] mask;
        mask = ~({MAX_VEC{1'b1}} << cw);
        return FIELD_W'((vec >> (i * cw)) & mask);
    endfunction

endpackage

// File: rtl/clock_phase_ch.sv
// One output channel: toggles its divided clock when the shared counter hits
// this channel's phase, and registers matching rise/fall strobes.
module clock_phase_ch
    import clock_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clkin,
    input  logic          RST,
    input  logic          en,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] phase,
    output logic          clk_out,
    output logic          rise_stb,
    output logic          fall_stb
);

    logic toggle;

    assign toggle = en && (cnt == phase);

    // Strobes mark the first cycle of each new level; a stopped channel is held low.
    always_ff @(posedge clkin or posedge RST) begin
        if (RST) begin
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else if (!en) begin
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            clk_out  <= clk_out ^ toggle;
            rise_stb <= toggle && !clk_out;
            fall_stb <= toggle && clk_out;
        end
    end

endmodule

// File: rtl/clock_phase_gen.sv
// Multi-channel 50%-duty clock divider with a shared programmable half-period,
// per-channel phase offsets and glitch-free reconfiguration at period boundaries.
module clock_phase_gen
    import clock_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int CW           = CW_DEFAULT,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT
) (
    input  logic              clkin,
    input  logic              RST,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [CW-1:0]     cfg_half,
    input  logic [NCH*CW-1:0] cfg_phase,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    rise_stb,
    output logic [NCH-1:0]    fall_stb,
    output logic              cfg_pending,
    output logic              locked
);

    logic [CW-1:0]     cnt;
    logic              half;
    logic [CW-1:0]     hlen;
    logic [NCH*CW-1:0] ph_vec;
    logic [CW-1:0]     pend_half;
    logic [NCH*CW-1:0] pend_phase;
    logic              idle;
    logic              lock_seen;

    logic              restart_apply;
    logic              bound_apply;
    logic              apply;
    logic              boundary;
    logic              at_end;
    logic              load_ok;
    logic [CW-1:0]     h_eff;
    logic [NCH*CW-1:0] ph_eff_vec;
    logic [CW-1:0]     ph_clamped [NCH];

    // A restart edge with a pending configuration already runs as t=0 of the new one.
    always_comb begin
        restart_apply = en && idle && cfg_pending;
        h_eff         = restart_apply ? pend_half : hlen;
        ph_eff_vec    = restart_apply ? pend_phase : ph_vec;
        at_end        = (cnt == h_eff - CW'(1));
        boundary      = en && !idle && half && at_end;
        bound_apply   = boundary && cfg_pending;
        apply         = restart_apply || bound_apply;
        load_ok       = cfg_load && (cfg_half != '0);
    end

    always_ff @(posedge clkin or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            half        <= 1'b0;
            hlen        <= CW'(DEFAULT_HALF);
            ph_vec      <= '0;
            pend_half   <= '0;
            pend_phase  <= '0;
            cfg_pending <= 1'b0;
            idle        <= 1'b1;
            lock_seen   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            if (!en) begin
                cnt       <= '0;
                half      <= 1'b0;
                idle      <= 1'b1;
                lock_seen <= 1'b0;
                locked    <= 1'b0;
            end else begin
                idle <= 1'b0;
                if (bound_apply) begin
                    cnt  <= '0;
                    half <= 1'b0;
                end else if (at_end) begin
                    cnt  <= '0;
                    half <= ~half;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if (apply) begin
                    hlen      <= pend_half;
                    ph_vec    <= pend_phase;
                    lock_seen <= 1'b0;
                    locked    <= 1'b0;
                end else if (boundary) begin
                    lock_seen <= 1'b1;
                    if (lock_seen) begin
                        locked <= 1'b1;
                    end
                end
            end
            // A load on the apply edge becomes the next pending configuration.
            if (load_ok) begin
                pend_half   <= cfg_half;
                pend_phase  <= cfg_phase;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ph_clamped[i] = CW'(clamp_phase(phase_slice(MAX_VEC'(ph_eff_vec), i, CW),
                                               FIELD_W'(h_eff)));

        clock_phase_ch #(
            .CW(CW)
        ) u_ch (
            .clkin    (clkin),
            .RST      (RST),
            .en       (en),
            .cnt      (cnt),
            .phase    (ph_clamped[i]),
            .clk_out  (clk_out[i]),
            .rise_stb (rise_stb[i]),
            .fall_stb (fall_stb[i])
        );
    end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen: walks through default run, phase offset,
// reconfiguration, clamping, enable gating and async reset.
module tb_clock_phase_gen;

    localparam int NCH   = 2;
    localparam int CW    = 8;
    localparam int NEVER = 100000;

    logic              clkin = 1'b0;
    logic              RST;
    logic              en;
    logic              cfg_load;
    logic [CW-1:0]     cfg_half;
    logic [NCH*CW-1:0] cfg_phase;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    rise_stb;
    logic [NCH-1:0]    fall_stb;
    logic              cfg_pending;
    logic              locked;

    int assertCount = 0;
    int failCount   = 0;
    int edgeNum     = 0;

    always #5 clkin = ~clkin;

    clock_phase_gen #(
        .NCH(NCH),
        .CW(CW),
        .DEFAULT_HALF(4)
    ) dut (
        .clkin       (clkin),
        .RST         (RST),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_half    (cfg_half),
        .cfg_phase   (cfg_phase),
        .clk_out     (clk_out),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .cfg_pending (cfg_pending),
        .locked      (locked)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic loadV,
                                 input logic [CW-1:0] halfV, input logic [NCH*CW-1:0] phaseV);
        en        = enV;
        cfg_load  = loadV;
        cfg_half  = halfV;
        cfg_phase = phaseV;
    endtask

    task automatic stepEdge();
        @(posedge clkin);
        #1;
        edgeNum++;
    endtask

    // Expected levels from the closed form: channel high while (t - ph) mod 2H < H.
    task automatic checkEdge(input string tag, input int base, input int h,
                             input int ph0, input int ph1,
                             input int pendFrom, input int pendTo,
                             input int lockFrom, input int lockTo);
        int t;
        logic [NCH-1:0] expClk, expRise, expFall;
        logic expPend, expLock;
        t = edgeNum - base;
        for (int c = 0; c < NCH; c++) begin
            int ph, d;
            ph = (c == 0) ? ph0 : ph1;
            d  = ((t - ph) % (2 * h) + 2 * h) % (2 * h);
            expClk[c]  = (d < h);
            expRise[c] = (d == 0);
            expFall[c] = (d == h);
        end
        expPend = (edgeNum >= pendFrom) && (edgeNum < pendTo);
        expLock = (edgeNum >= lockFrom) && (edgeNum < lockTo);
        checkOutput($sformatf("%s clk e%0d", tag, edgeNum), 32'(clk_out), 32'(expClk));
        checkOutput($sformatf("%s rise e%0d", tag, edgeNum), 32'(rise_stb), 32'(expRise));
        checkOutput($sformatf("%s fall e%0d", tag, edgeNum), 32'(fall_stb), 32'(expFall));
        checkOutput($sformatf("%s pend/lock e%0d", tag, edgeNum),
                    32'({cfg_pending, locked}), 32'({expPend, expLock}));
    endtask

    task automatic runSpan(input int count, input string tag, input int base, input int h,
                           input int ph0, input int ph1,
                           input int pendFrom, input int pendTo,
                           input int lockFrom, input int lockTo);
        repeat (count) begin
            stepEdge();
            checkEdge(tag, base, h, ph0, ph1, pendFrom, pendTo, lockFrom, lockTo);
        end
    endtask

    task automatic checkIdle(input string tag, input logic expPend);
        checkOutput($sformatf("%s clk", tag), 32'(clk_out), 32'd0);
        checkOutput($sformatf("%s rise", tag), 32'(rise_stb), 32'd0);
        checkOutput($sformatf("%s fall", tag), 32'(fall_stb), 32'd0);
        checkOutput($sformatf("%s pend/lock", tag), 32'({cfg_pending, locked}),
                    32'({expPend, 1'b0}));
    endtask

    initial begin
        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0000);
        #2;
        checkIdle("reset", 1'b0);
        #1;
        RST = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);

        // Defaults: H=4, both phases 0, lock after edge 16.
        runSpan(24, "dflt", 1, 4, 0, 0, 0, 0, 16, NEVER);

        // Phase offset: ch1 lags by 2; applied at boundary edge 32.
        applyStimulus(1'b1, 1'b1, 8'd4, {8'd2, 8'd0});
        runSpan(1, "ldB", 1, 4, 0, 0, 25, 32, 16, 32);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        runSpan(7, "ldB", 1, 4, 0, 0, 25, 32, 16, 32);
        runSpan(18, "phase", 33, 4, 0, 2, 0, 0, 48, NEVER);

        // Mid-period reload to H=3; takes effect at boundary edge 56.
        applyStimulus(1'b1, 1'b1, 8'd3, {8'd1, 8'd0});
        runSpan(1, "ldC", 33, 4, 0, 2, 51, 56, 48, 56);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        runSpan(5, "ldC", 33, 4, 0, 2, 51, 56, 48, 56);
        runSpan(14, "h3", 57, 3, 0, 1, 0, 0, 68, NEVER);

        // H=2 with ph1=7 clamps to 1; apply at edge 74.
        applyStimulus(1'b1, 1'b1, 8'd2, {8'd7, 8'd0});
        runSpan(1, "ldD", 57, 3, 0, 1, 71, 74, 68, 74);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        runSpan(3, "ldD", 57, 3, 0, 1, 71, 74, 68, 74);
        runSpan(10, "clamp", 75, 2, 0, 1, 0, 0, 82, NEVER);

        // Zero half-period load is ignored.
        applyStimulus(1'b1, 1'b1, 8'd0, {8'd5, 8'd5});
        runSpan(1, "h0", 75, 2, 0, 1, 0, 0, 82, NEVER);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        runSpan(7, "h0", 75, 2, 0, 1, 0, 0, 82, NEVER);

        // Enable gating, then restart from t=0.
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0000);
        stepEdge();
        checkIdle("enoff e93", 1'b0);
        stepEdge();
        checkIdle("enoff e94", 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        runSpan(6, "restart", 95, 2, 0, 1, 0, 0, 102, NEVER);

        // Load while stopped: applied on the restart edge as its t=0.
        applyStimulus(1'b0, 1'b1, 8'd5, {8'd3, 8'd0});
        stepEdge();
        checkIdle("offload e101", 1'b1);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0000);
        stepEdge();
        checkIdle("offload e102", 1'b1);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        runSpan(22, "h5", 103, 5, 0, 3, 0, 0, 122, NEVER);

        // Load coinciding with the apply edge: old pending applies, new stays pending.
        applyStimulus(1'b1, 1'b1, 8'd3, {8'd0, 8'd0});
        runSpan(1, "ldA", 103, 5, 0, 3, 125, NEVER, 122, NEVER);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        runSpan(6, "ldA", 103, 5, 0, 3, 125, NEVER, 122, NEVER);
        applyStimulus(1'b1, 1'b1, 8'd4, {8'd1, 8'd0});
        runSpan(1, "simul", 103, 5, 0, 3, 125, 138, 122, 132);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        runSpan(6, "cfgA", 133, 3, 0, 0, 125, 138, NEVER, NEVER);
        runSpan(18, "cfgB", 139, 4, 0, 1, 0, 0, 154, NEVER);

        // Async reset while both channels high and a load is pending.
        applyStimulus(1'b1, 1'b1, 8'd6, {8'd0, 8'd0});
        runSpan(1, "preRst", 139, 4, 0, 1, 157, NEVER, 154, NEVER);
        checkOutput("preRst both high", 32'(clk_out), 32'd3);
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0000);
        #3;
        RST = 1'b1;
        #1;
        checkIdle("asyncRst", 1'b0);
        #1;
        RST = 1'b0;
        runSpan(17, "postRst", 158, 4, 0, 0, 0, 0, 173, NEVER);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
